fp_mult_share_arbiter: RTL
==========================

# fp_mult_share_arbiter

Round-robin scheduler that shares one multi-cycle floating-point multiplier (enable/done handshake) between `N_REQ` requesters. It lets pipelines such as the CORDIC expression evaluator time-multiplex a single multiplier instead of instantiating several. Each requester sees a level request/one-cycle response protocol. A watchdog guarantees forward progress if the multiplier never reports done.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand/result width (IEEE-754 single)
- `TIMEOUT_CYCLES`, 64, cycles of mul_enable without mul_done before forced abort (≥ 2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  N_REQ  per-requester level request; operands stable while high
- `req_dataa`  in  N_REQ*WIDTH  packed operand A, slice i for requester i
- `req_datab`  in  N_REQ*WIDTH  packed operand B
- `grant`  out  N_REQ  one-hot, high while requester's job owns the multiplier
- `resp_valid`  out  N_REQ  one-cycle pulse, result for requester i ready
- `resp_result`  out  WIDTH  result, valid when any resp_valid bit high
- `resp_error`  out  1  qualifies resp_valid: job aborted by timeout
- `busy`  out  1  state ≠ IDLE
- `mul_dataa`, `mul_datab`  out  WIDTH  registered operands to shared multiplier
- `mul_enable`  out  1  level enable to multiplier
- `mul_done`  in  1  multiplier done level, held until enable drops
- `mul_result`  in  WIDTH  multiplier result, valid with mul_done

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE: if any `req` bit is high, pick the winner by round-robin starting at `ptr`. Latch its operands into `mul_dataa/b`, set `grant[win]`, set `mul_enable`=1, clear the timeout counter, and go to BUSY. Otherwise stay.
- BUSY: the counter increments each cycle.
  - If `mul_done`=1: register `mul_result`→`resp_result`, pulse `resp_valid[win]`, `resp_error`=0, `mul_enable`=0, clear `grant`, `ptr`←win+1 (mod N_REQ), go to DRAIN.
  - Else, if the counter reaches TIMEOUT_CYCLES−1: same actions, except `resp_result`=32'h7FC00000 (quiet NaN) and `resp_error`=1.
  - `mul_done` takes priority over timeout in the same cycle.
- DRAIN: `mul_enable` stays 0. Go to IDLE in the first cycle `mul_done` is sampled 0. DRAIN always lasts at least one cycle.
- Requester rule: drop `req` on the edge after its `resp_valid` pulse. The arbiter does not re-serve a requester whose `req` is still high in the DRAIN exit cycle; such a request is treated as new.
- Only the winner's `req` is ignored once latched. Dropping `req` while granted does not abort the job; the response is still pulsed.
- `ptr` advances only on completion, so the last-served requester has lowest priority next time.
- Reset values: state IDLE, `ptr`=0, all outputs 0 (`grant`, `resp_valid`, `resp_result`, `resp_error`, `busy`, `mul_enable`, `mul_dataa/b`).
- Reset mid-operation: the job is discarded, no `resp_valid` is issued, and `mul_enable` is low in the next cycle.

## Timing
- Let `req` be sampled at edge t in IDLE. At t+1, `mul_enable`=1, `grant` valid, operands stable.
- Let the multiplier raise `mul_done` L cycles after enable. Then `resp_valid` is high in cycle t+1+L+1, and `mul_enable` is low in the same cycle.
- DRAIN lasts ≥1 cycle. Minimum issue-to-issue spacing is L+3 cycles.
- `resp_valid` is registered, exactly one bit high, for exactly one cycle.
- `resp_result` holds its value until the next response.
- Timeout response arrives TIMEOUT_CYCLES cycles after `mul_enable` rises.

## Structure
- Package `fp_sched_pkg`: state enum `sched_state_t` (IDLE/BUSY/DRAIN), `FP_QNAN = 32'h7FC00000`, `FP_WIDTH = 32`.
- Sub-module `rr_priority_pick` (combinational): inputs `req`, `ptr`; outputs `win` index and `any`. Reused by other shared-unit arbiters (adder, subtractor).
- Top: FSM, operand/result registers, timeout counter ($clog2(TIMEOUT_CYCLES) bits), `ptr` register.

## Test plan
- Single request: req[2]=1, A=0x40000000, B=0x40400000, model L=5 → `mul_enable` rises at t+1; `resp_valid[2]` at t+7 with result 0x40C00000; `grant`=0 afterwards.
- All four `req` high continuously, ptr=0 → service order 0,1,2,3,0.
  - Each grant is one-hot.
  - Spacing is L+3 cycles.
  - Each requester receives its own product.
- Starvation check: req[0] toggles per transaction while req[3] is held → req[3] is served within N_REQ transactions.
- Timeout: model never asserts `mul_done`, TIMEOUT_CYCLES=64 → `resp_valid[1]` 64 cycles after enable, `resp_error`=1, result 0x7FC00000. Next request proceeds normally.
- `mul_done` and timeout coincide at count 63 → `resp_error`=0, real result returned.
- `reset` asserted in BUSY → next cycle all outputs 0, no `resp_valid`. A request after reset release is served from ptr=0.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared state type and IEEE-754 constants for the shared floating-point unit schedulers.
package fp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int                  FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] FP_QNAN  = 32'h7FC0_0000;

endpackage

// File: rtl/fp_mult_share_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N_REQ.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             any
);

    // Scan from the farthest slot down so the slot nearest ptr is the last (winning) hit.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            win = req[idx] ? idx : win;
            any = any | req[idx];
        end
    end

endmodule

// File: rtl/fp_mult_share_arbiter.sv
// Round-robin scheduler sharing one multi-cycle multiplier (enable/done handshake)
// between N_REQ requesters, with a watchdog that aborts a job the multiplier never finishes.
module fp_mult_share_arbiter
    import fp_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = FP_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_dataa,
    input  logic [N_REQ*WIDTH-1:0] req_datab,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_result,
    output logic                   resp_error,
    output logic                   busy,
    output logic [WIDTH-1:0]       mul_dataa,
    output logic [WIDTH-1:0]       mul_datab,
    output logic                   mul_enable,
    input  logic                   mul_done,
    input  logic [WIDTH-1:0]       mul_result
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(N_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1'b1);
        end
        return nxt;
    endfunction

    sched_state_t     state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [IDX_W-1:0] win_r, win_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [N_REQ-1:0] grant_r, grant_s;
    logic [N_REQ-1:0] resp_valid_r, resp_valid_s;
    logic [WIDTH-1:0] resp_result_r, resp_result_s;
    logic             resp_error_r, resp_error_s;
    logic             busy_r, busy_s;
    logic [WIDTH-1:0] mul_dataa_r, mul_dataa_s;
    logic [WIDTH-1:0] mul_datab_r, mul_datab_s;
    logic             mul_enable_r, mul_enable_s;
    logic [IDX_W-1:0] pick_win_s;
    logic             pick_any_s;
    logic [WIDTH-1:0] opa_s [N_REQ];
    logic [WIDTH-1:0] opb_s [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign opa_s[i] = req_dataa[i*WIDTH +: WIDTH];
        assign opb_s[i] = req_datab[i*WIDTH +: WIDTH];
    end

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_r),
        .win (pick_win_s),
        .any (pick_any_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        win_s         = win_r;
        cnt_s         = cnt_r;
        grant_s       = grant_r;
        resp_valid_s  = '0;
        resp_result_s = resp_result_r;
        resp_error_s  = resp_error_r;
        busy_s        = busy_r;
        mul_dataa_s   = mul_dataa_r;
        mul_datab_s   = mul_datab_r;
        mul_enable_s  = mul_enable_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    win_s        = pick_win_s;
                    mul_dataa_s  = opa_s[pick_win_s];
                    mul_datab_s  = opb_s[pick_win_s];
                    grant_s      = ONE_HOT0 << pick_win_s;
                    mul_enable_s = 1'b1;
                    cnt_s        = '0;
                    busy_s       = 1'b1;
                    state_s      = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                cnt_s = cnt_r + CNT_W'(1'b1);
                // A real result wins over the watchdog when both land in the same cycle.
                if (mul_done || (cnt_r == CNT_LAST)) begin
                    resp_result_s = mul_done ? mul_result : WIDTH'(FP_QNAN);
                    resp_error_s  = ~mul_done;
                    resp_valid_s  = ONE_HOT0 << win_r;
                    grant_s       = '0;
                    mul_enable_s  = 1'b0;
                    ptr_s         = next_ptr(win_r);
                    state_s       = DRAIN;
                end else begin
                    state_s = BUSY;
                end
            end
            DRAIN: begin
                if (!mul_done) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                grant_s      = '0;
                mul_enable_s = 1'b0;
                busy_s       = 1'b0;
                state_s      = IDLE;
            end
        endcase
    end

    // State, pointer, watchdog counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            ptr_r         <= '0;
            win_r         <= '0;
            cnt_r         <= '0;
            grant_r       <= '0;
            resp_valid_r  <= '0;
            resp_result_r <= '0;
            resp_error_r  <= 1'b0;
            busy_r        <= 1'b0;
            mul_dataa_r   <= '0;
            mul_datab_r   <= '0;
            mul_enable_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            win_r         <= win_s;
            cnt_r         <= cnt_s;
            grant_r       <= grant_s;
            resp_valid_r  <= resp_valid_s;
            resp_result_r <= resp_result_s;
            resp_error_r  <= resp_error_s;
            busy_r        <= busy_s;
            mul_dataa_r   <= mul_dataa_s;
            mul_datab_r   <= mul_datab_s;
            mul_enable_r  <= mul_enable_s;
        end
    end

    assign grant       = grant_r;
    assign resp_valid  = resp_valid_r;
    assign resp_result = resp_result_r;
    assign resp_error  = resp_error_r;
    assign busy        = busy_r;
    assign mul_dataa   = mul_dataa_r;
    assign mul_datab   = mul_datab_r;
    assign mul_enable  = mul_enable_r;

endmodule
